// File: rtl/cache_mem_tester_pkg.sv
// Shared types and helpers for the cache memory tester: FSM encoding,
// error counter width and the write/read data pattern.
package cache_mem_tester_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    DONE     = 3'd5
  } state_t;

  function automatic logic [31:0] pattern(input logic [31:0] idx,
                                          input logic [31:0] xor_mask);
    return idx ^ xor_mask;
  endfunction

endpackage

// File: rtl/cache_mem_tester_wait_timer.sv
// Per-operation wait counter: cleared while an operation is issued, counts
// wait cycles and flags once TIMEOUT_CYCLES have elapsed.
module wait_timer #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT_CYCLES));

  // Count saturates at the limit so expired stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      count <= '0;
    else if (clear)               count <= '0;
    else if (enable && !expired)  count <= count + CW'(1);
  end

endmodule

// File: rtl/cache_mem_tester.sv
// Sequential write-then-read-back tester for a word-addressed cache: writes
// 2^N pattern words, reads them back, and reports mismatches and timeouts.
module cache_mem_tester
  import cache_mem_tester_pkg::*;
#(
  parameter int          ADDR_COUNT_BITWIDTH = 10,
  parameter logic [31:0] PATTERN_XOR         = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES      = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [31:0]      address,
  output logic [31:0]      data_in,
  output logic [3:0]       write_enable,
  input  logic [31:0]      data_out,
  input  logic             data_out_ready,
  input  logic             busy,
  output logic             running,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [ERR_W-1:0] error_count,
  output logic [31:0]      fail_address,
  output logic [31:0]      fail_data
);

  localparam int IW = ADDR_COUNT_BITWIDTH;
  localparam logic [IW-1:0] LAST_IDX = '1;

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic [ERR_W-1:0] err_next;
  logic [31:0]     fa_next, fd_next, exp_word;
  logic            to_next, pass_next;
  logic            timer_clear, timer_en, expired;

  assign exp_word    = pattern(32'(idx), PATTERN_XOR);
  assign running     = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  // Clearing during the issue cycle means every wait starts from zero.
  assign timer_clear = (state == WR_ISSUE) || (state == RD_ISSUE);
  assign timer_en    = (state == WR_WAIT) || (state == RD_WAIT);

  wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    err_next   = error_count;
    fa_next    = fail_address;
    fd_next    = fail_data;
    to_next    = timeout;
    pass_next  = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = WR_ISSUE;
          idx_next   = '0;
          err_next   = '0;
          fa_next    = '0;
          fd_next    = '0;
          to_next    = 1'b0;
          pass_next  = 1'b0;
        end
      end
      WR_ISSUE: state_next = WR_WAIT;
      WR_WAIT: begin
        if (!busy) begin
          if (idx == LAST_IDX) begin
            state_next = RD_ISSUE;
            idx_next   = '0;
          end else begin
            state_next = WR_ISSUE;
            idx_next   = idx + IW'(1);
          end
        end else if (expired) begin
          state_next = DONE;
          to_next    = 1'b1;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        if (data_out_ready) begin
          if (data_out != exp_word) begin
            if (error_count != '1) err_next = error_count + ERR_W'(1);
            if (error_count == '0) begin
              fa_next = address;
              fd_next = data_out;
            end
          end
          if (idx == LAST_IDX) begin
            state_next = DONE;
          end else begin
            state_next = RD_ISSUE;
            idx_next   = idx + IW'(1);
          end
        end else if (expired) begin
          state_next = DONE;
          to_next    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == DONE && state != DONE)
      pass_next = (err_next == '0) && !to_next;
  end

  // Cache-facing outputs are registered from the next state so they are
  // valid for the whole issue cycle and held through the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      error_count  <= '0;
      fail_address <= '0;
      fail_data    <= '0;
      timeout      <= 1'b0;
      pass         <= 1'b0;
      address      <= '0;
      data_in      <= '0;
      write_enable <= 4'h0;
    end else begin
      idx          <= idx_next;
      error_count  <= err_next;
      fail_address <= fa_next;
      fail_data    <= fd_next;
      timeout      <= to_next;
      pass         <= pass_next;
      write_enable <= (state_next == WR_ISSUE) ? 4'hF : 4'h0;
      if (state_next == WR_ISSUE || state_next == RD_ISSUE)
        address <= 32'(idx_next) << 2;
      if (state_next == WR_ISSUE)
        data_in <= pattern(32'(idx_next), PATTERN_XOR);
    end
  end

endmodule

// File: doc/cache_mem_tester.md
CACHE_MEM_TESTER -- requirements
Module: cache_mem_tester

Interface
REQ-001 SHALL have parameter ADDR_COUNT_BITWIDTH, default 10; the test covers 2^N consecutive 32-bit words starting at byte address 0.
REQ-002 SHALL have parameter PATTERN_XOR, default 32'h0000_0000; the word written at index i is i XOR PATTERN_XOR.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1023; this is the maximum number of wait cycles allowed per operation.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a test run.
REQ-007 address  output  32  byte address to cache, word aligned.
REQ-008 data_in  output  32  write data to cache.
REQ-009 write_enable  output  4  byte enables; 4'b1111 for a write, 0 for a read.
REQ-010 data_out  input  32  cache read data.
REQ-011 data_out_ready  input  1  cache read data valid.
REQ-012 busy  input  1  cache stalled (miss/eviction in progress).
REQ-013 running  output  1  test in progress.
REQ-014 done  output  1  test finished; held until next start.
REQ-015 pass  output  1  valid when done: no mismatch and no timeout.
REQ-016 timeout  output  1  an operation exceeded TIMEOUT_CYCLES.
REQ-017 error_count  output  16  read mismatches, saturating at 16'hFFFF.
REQ-018 fail_address / fail_data  output  32 each  address and data_out of the first mismatch.

Function
REQ-019 FSM states: IDLE, WR_ISSUE, WR_WAIT, RD_ISSUE, RD_WAIT, DONE.
REQ-020 IDLE/DONE + start -> WR_ISSUE; index = 0; error_count, fail_*, timeout and pass are cleared; done = 0.
REQ-021 WR_ISSUE: drive address = index*4, data_in = pattern(index) and write_enable = 4'b1111 for exactly one cycle, then go to WR_WAIT.
REQ-022 WR_WAIT: write_enable = 0; address and data_in are held; leave when busy = 0 (this may be the first WR_WAIT cycle).
  - Last index -> RD_ISSUE with index = 0.
  - Otherwise -> WR_ISSUE with index + 1.
REQ-023 RD_ISSUE: drive address = index*4 with write_enable = 0 for one cycle, then go to RD_WAIT.
REQ-024 RD_WAIT: address is held; when data_out_ready = 1, compare data_out against pattern(index).
  - On mismatch, error_count increments; on the first mismatch only, fail_address and fail_data are captured.
  - Last index -> DONE; otherwise -> RD_ISSUE with index + 1.
REQ-025 A single write takes at least 2 cycles and a single read at least 2 cycles; there is no pipelining of operations.
REQ-026 Timeout: the wait counter is cleared on entry to WR_WAIT and RD_WAIT. If the counter reaches TIMEOUT_CYCLES, set timeout = 1 and go to DONE. No further cache operations are issued.
REQ-027 DONE: done = 1, running = 0, and pass = (error_count == 0) && !timeout.
REQ-028 start is ignored while running = 1.
REQ-029 The index counter is ADDR_COUNT_BITWIDTH bits wide; the last-index test is index == all ones, so the counter never wraps.
REQ-030 running = 1 in all states except IDLE and DONE.

Reset
REQ-031 While rst = 1, all of the following are forced to 0 asynchronously: state = IDLE, address, data_in, write_enable, running, done, pass, timeout, error_count, fail_address, fail_data, index and the wait counter.
REQ-032 Reset asserted mid-operation aborts the run immediately; write_enable = 0 in the same cycle; no partial result is retained.
REQ-033 After rst deasserts, the block waits in IDLE for start.

Structure
REQ-034 The state enum, the pattern function and the error_count width belong in package cache_mem_tester_pkg.
REQ-035 The timeout logic is sub-module wait_timer: inputs clear and enable, output expired, parameterised by TIMEOUT_CYCLES.

Verification
REQ-036 A cache plus a 1024-word burst RAM model, with start pulsed: the run completes and done = 1, pass = 1, error_count = 0. The write phase covers addresses 0..0xFFC.
REQ-037 A fault is injected so that data_out at address 0x8 returns 32'hDEAD_BEEF. Required result: pass = 0, error_count = 1, fail_address = 0x8, fail_data = 32'hDEAD_BEEF.
REQ-038 busy is held at 1 indefinitely with TIMEOUT_CYCLES = 15. Required result: timeout = 1 and done = 1 exactly 16 cycles after entering WR_WAIT; write_enable stays 0 thereafter.
REQ-039 rst is asserted during RD_WAIT at index 100. Required result: all outputs are 0 in the same cycle, and a new start produces a clean pass.
REQ-040 start is pulsed again while running = 1: no effect. start is pulsed in DONE after the failing run of REQ-037 with the fault removed: error_count and fail_* clear and pass = 1.
REQ-041 With PATTERN_XOR = 32'hFFFF_FFFF, the word at address 0x4 is written as 32'hFFFF_FFFE and the read check passes.
